reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit general-purpose register file with a per-register
// pending-write scoreboard for an in-order issue stage.
//
// Ports
//   clk               core clock, all state updates on the rising edge
//   rst               asynchronous active-low reset
//   issue_en          ID requests to issue an instruction this cycle
//   read_en_1/2       source operand read enables
//   read_addr_1/2     source register addresses
//   issue_write_en    issuing instruction writes a GPR
//   issue_write_addr  destination GPR of the issuing instruction
//   wb_en             writeback valid
//   wb_addr           writeback destination GPR
//   wb_data           writeback value
//   read_data_1/2     combinational operand values (writeback bypassed)
//   stall             ID must hold; the issue is not accepted this cycle
//   sb_error          sticky flag: writeback arrived for a GPR with nothing pending
module reg_file_sb (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_en,
   input  logic        read_en_1,
   input  logic        read_en_2,
   input  logic [4:0]  read_addr_1,
   input  logic [4:0]  read_addr_2,
   input  logic        issue_write_en,
   input  logic [4:0]  issue_write_addr,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [31:0] read_data_1,
   output logic [31:0] read_data_2,
   output logic        stall,
   output logic        sb_error
);

   logic [31:0] r_gpr  [32];
   logic [1:0]  r_pend [32];
   logic        r_sb_error;

   logic        w_haz_1;
   logic        w_haz_2;
   logic        w_haz_d;
   logic        w_accept;
   logic [31:0] w_inc;
   logic [31:0] w_dec;

   // Operand reads with write-through bypass of the same-cycle writeback.
   always_comb begin
      read_data_1 = '0;
      if (read_en_1 && read_addr_1 != '0) begin
         if (wb_en && wb_addr == read_addr_1) read_data_1 = wb_data;
         else                                 read_data_1 = r_gpr[read_addr_1];
      end
   end

   always_comb begin
      read_data_2 = '0;
      if (read_en_2 && read_addr_2 != '0) begin
         if (wb_en && wb_addr == read_addr_2) read_data_2 = wb_data;
         else                                 read_data_2 = r_gpr[read_addr_2];
      end
   end

   // A source is only rescued by the bypass when the arriving writeback is the
   // last outstanding one; older writebacks would hand over a stale value.
   always_comb begin
      w_haz_1 = read_en_1 && read_addr_1 != '0 && r_pend[read_addr_1] != 2'd0 &&
                !(r_pend[read_addr_1] == 2'd1 && wb_en && wb_addr == read_addr_1);
      w_haz_2 = read_en_2 && read_addr_2 != '0 && r_pend[read_addr_2] != 2'd0 &&
                !(r_pend[read_addr_2] == 2'd1 && wb_en && wb_addr == read_addr_2);
      // Counter is saturated; accept only if a writeback frees a slot this cycle.
      w_haz_d = issue_write_en && issue_write_addr != '0 &&
                r_pend[issue_write_addr] == 2'd3 &&
                !(wb_en && wb_addr == issue_write_addr);
      stall    = issue_en && (w_haz_1 || w_haz_2 || w_haz_d);
      w_accept = issue_en && !stall;
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      if (w_accept && issue_write_en && issue_write_addr != '0)
         w_inc[issue_write_addr] = 1'b1;
      if (wb_en && wb_addr != '0)
         w_dec[wb_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            r_gpr[i]  <= '0;
            r_pend[i] <= '0;
         end
         r_sb_error <= 1'b0;
      end else begin
         if (wb_en && wb_addr != '0) begin
            r_gpr[wb_addr] <= wb_data;
            if (r_pend[wb_addr] == 2'd0) r_sb_error <= 1'b1;
         end
         // Simultaneous issue and writeback on one GPR cancel out; a writeback
         // with nothing pending leaves the counter at zero.
         for (int unsigned i = 0; i < 32; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_pend[i] <= r_pend[i] + 2'd1;
            else if (w_dec[i] && !w_inc[i] && r_pend[i] != 2'd0)
               r_pend[i] <= r_pend[i] - 2'd1;
         end
      end
   end

   assign sb_error = r_sb_error;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb. The driver applies one
// input vector per cycle, predicts the combinational outputs from a
// behavioural model and queues them; the monitor pops and compares on every
// falling edge.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_en, read_en_1, read_en_2, issue_write_en, wb_en;
   logic [4:0]  read_addr_1, read_addr_2, issue_write_addr, wb_addr;
   logic [31:0] wb_data;
   logic [31:0] read_data_1, read_data_2;
   logic        stall, sb_error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk              (clk),
      .rst              (rst),
      .issue_en         (issue_en),
      .read_en_1        (read_en_1),
      .read_en_2        (read_en_2),
      .read_addr_1      (read_addr_1),
      .read_addr_2      (read_addr_2),
      .issue_write_en   (issue_write_en),
      .issue_write_addr (issue_write_addr),
      .wb_en            (wb_en),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .read_data_1      (read_data_1),
      .read_data_2      (read_data_2),
      .stall            (stall),
      .sb_error         (sb_error)
   );

   typedef struct {
      string       name;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        st;
      logic        err;
   } exp_t;

   exp_t q[$];

   // Behavioural model: architectural register values, outstanding-write
   // counts and the sticky error flag.
   logic [31:0] m_gpr  [32];
   int          m_pend [32];
   bit          m_err;

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) begin
         m_gpr[i]  = '0;
         m_pend[i] = 0;
      end
      m_err = 1'b0;
   endfunction

   function automatic logic [31:0] m_read(logic en, logic [4:0] a, logic wbe,
                                          logic [4:0] wba, logic [31:0] wbd);
      if (!en || a == 0) return 32'd0;
      if (wbe && wba == a) return wbd;
      return m_gpr[a];
   endfunction

   function automatic bit m_src_haz(logic en, logic [4:0] a, logic wbe, logic [4:0] wba);
      if (!en || a == 0 || m_pend[a] == 0) return 1'b0;
      if (m_pend[a] == 1 && wbe && wba == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_stall(logic ie, logic e1, logic [4:0] a1, logic e2,
                                  logic [4:0] a2, logic iwe, logic [4:0] iwa,
                                  logic wbe, logic [4:0] wba);
      bit hd;
      if (!ie) return 1'b0;
      hd = iwe && iwa != 0 && m_pend[iwa] == 3 && !(wbe && wba == iwa);
      return m_src_haz(e1, a1, wbe, wba) || m_src_haz(e2, a2, wbe, wba) || hd;
   endfunction

   function automatic void m_commit(bit acc, logic iwe, logic [4:0] iwa,
                                    logic wbe, logic [4:0] wba, logic [31:0] wbd);
      bit inc, dec;
      inc = acc && iwe && iwa != 0;
      dec = wbe && wba != 0;
      if (dec) begin
         m_gpr[wba] = wbd;
         if (m_pend[wba] == 0) m_err = 1'b1;
      end
      if (inc && dec && iwa == wba) return;
      if (inc) m_pend[iwa] = m_pend[iwa] + 1;
      if (dec && m_pend[wba] > 0) m_pend[wba] = m_pend[wba] - 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: apply inputs, predict outputs, advance the model.
   task automatic step(input string nm, input logic rv, input logic ie,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2,
                       input logic iwe, input logic [4:0] iwa,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
      exp_t e;
      bit   acc;
      rst = rv; issue_en = ie;
      read_en_1 = e1; read_addr_1 = a1; read_en_2 = e2; read_addr_2 = a2;
      issue_write_en = iwe; issue_write_addr = iwa;
      wb_en = wbe; wb_addr = wba; wb_data = wbd;
      if (!rv) m_reset();
      e.name = nm;
      e.rd1  = m_read(e1, a1, wbe, wba, wbd);
      e.rd2  = m_read(e2, a2, wbe, wba, wbd);
      e.st   = m_stall(ie, e1, a1, e2, a2, iwe, iwa, wbe, wba);
      e.err  = m_err;
      q.push_back(e);
      acc = ie && !e.st;
      @(posedge clk);
      if (rv) m_commit(acc, iwe, iwa, wbe, wba, wbd);
      #1;
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".rd1"},  read_data_1,      e.rd1);
            chk({e.name, ".rd2"},  read_data_2,      e.rd2);
            chk({e.name, ".stall"}, {31'd0, stall},   {31'd0, e.st});
            chk({e.name, ".err"},  {31'd0, sb_error}, {31'd0, e.err});
         end
      end
   end

   initial begin
      rst = 1'b0; issue_en = 0; read_en_1 = 0; read_en_2 = 0; read_addr_1 = 0;
      read_addr_2 = 0; issue_write_en = 0; issue_write_addr = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0;
      m_reset();
      @(posedge clk); #1;

      //           name      rst ie e1 a1 e2 a2 iwe iwa wbe wba wbd
      step("rst0",     0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0);
      step("rst1",     0, 1, 1, 5, 1, 3, 1, 3, 0, 0, 32'h0);
      step("idle_r5",  1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0);

      // Read-after-write hazard resolved by the final writeback bypass.
      step("iss_w3",   1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0);
      step("rd3_haz",  1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0);
      step("rd3_byp",  1, 1, 1, 3, 0, 0, 0, 0, 1, 3, 32'h1234);
      step("rd3_free", 1, 1, 1, 3, 1, 3, 0, 0, 0, 0, 32'h0);

      // Counter saturation on r7.
      step("w7_a",     1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
      step("w7_b",     1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
      step("w7_c",     1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
      step("w7_full",  1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
      step("w7_swap",  1, 1, 0, 0, 0, 0, 1, 7, 1, 7, 32'h70);
      step("w7_still", 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
      step("w7_d1",    1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h71);
      step("w7_d2",    1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h72);
      step("w7_d3",    1, 1, 1, 7, 0, 0, 0, 0, 1, 7, 32'h73);

      // Bypass only applies to the last outstanding write.
      step("w4_a",     1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0);
      step("w4_b",     1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0);
      step("rd4_old",  1, 1, 0, 0, 1, 4, 0, 0, 1, 4, 32'hA);
      step("rd4_new",  1, 1, 0, 0, 1, 4, 0, 0, 1, 4, 32'hB);

      // Unmatched writeback and writes to r0.
      step("wb9_err",  1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'hFF);
      step("rd9",      1, 1, 1, 9, 0, 0, 0, 0, 1, 0, 32'h123);
      step("rd0",      1, 1, 1, 0, 1, 9, 0, 0, 0, 0, 32'h0);

      // Reset in the middle of outstanding work.
      step("w2_a",     1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 32'h0);
      step("w2_b",     1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 32'h0);
      step("w2_wb",    1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 32'h55);
      step("rd2_haz",  1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0);
      step("rst_mid",  0, 1, 1, 2, 1, 2, 1, 2, 0, 0, 32'h0);
      step("rd2_clr",  1, 1, 1, 2, 1, 2, 0, 0, 0, 0, 32'h0);

      for (int n = 0; n < 400; n++) begin
         logic rv;
         rv = ($urandom_range(0, 39) != 0);
         step("rand", rv, ($urandom_range(0, 3) != 0),
              1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end

      step("tail", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d queued expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
